cond_logic_unit: RTL

COND_LOGIC_UNIT -- requirements
Module: cond_logic_unit

---
 rtl/cond_logic_unit_pkg.sv | 41 ++++
 rtl/cond_logic_unit_cond_check.sv | 44 ++++
 rtl/cond_logic_unit.sv | 72 +++++++
 3 files changed

// File: rtl/cond_logic_unit_pkg.sv
// Shared CPU package: condition-code encodings, flag bit positions and
// flag-write request encodings used by the conditional-execution logic.
package cond_logic_unit_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_CV   = 2'b01;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;

    localparam int unsigned FLAGW_CV_BIT = 0;
    localparam int unsigned FLAGW_NZ_BIT = 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (&value) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/cond_logic_unit_cond_check.sv
// Purely combinational condition evaluator: maps an instruction's condition
// field and the architectural {N,Z,C,V} flags to a single execute decision.
module cond_check
    import cond_logic_unit_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            EQ:      CondEx = z;
            NE:      CondEx = ~z;
            CS:      CondEx = c;
            CC:      CondEx = ~c;
            MI:      CondEx = n;
            PL:      CondEx = ~n;
            VS:      CondEx = v;
            VC:      CondEx = ~v;
            HI:      CondEx = c & ~z;
            LS:      CondEx = ~c | z;
            GE:      CondEx = (n == v);
            LT:      CondEx = (n != v);
            GT:      CondEx = ~z & (n == v);
            LE:      CondEx = z | (n != v);
            AL:      CondEx = 1'b1;
            // NV is reserved and never executes
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic_unit.sv
// Conditional-execution unit: holds the {N,Z,C,V} flags and gates the
// decoder's write requests. Optional skip counter under COND_SKIP_STATS_EN.
module cond_logic_unit
    import cond_logic_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        CondEx,
`ifdef COND_SKIP_STATS_EN
    output logic [15:0] SkipCount,
`endif
    output logic [3:0]  Flags
);

    logic [1:0] flag_half_reg [2];
    logic [1:0] flag_we;
    logic       exec_en;

    // Evaluated against registered flags only, so a write lands next cycle.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (CondEx)
    );

    assign exec_en  = En & CondEx;
    assign PCSrc    = PCS  & exec_en;
    assign RegWrite = RegW & exec_en;
    assign MemWrite = MemW & exec_en;

    // Half 0 holds {C,V}, half 1 holds {N,Z}; FlagW bit gi selects half gi.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
            assign flag_we[gi] = exec_en & FlagW[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    flag_half_reg[gi] <= 2'b00;
                end else if (flag_we[gi]) begin
                    flag_half_reg[gi] <= ALUFlags[2*gi +: 2];
                end
            end
        end
    endgenerate

    assign Flags = {flag_half_reg[1], flag_half_reg[0]};

`ifdef COND_SKIP_STATS_EN
    logic [15:0] skip_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_cnt_reg <= 16'd0;
        end else if (En & ~CondEx) begin
            skip_cnt_reg <= sat_inc16(skip_cnt_reg);
        end
    end

    assign SkipCount = skip_cnt_reg;
`endif

endmodule
